irq_controller: RTL and testbench
=================================

# irq_controller

Parametrised interrupt controller sitting between the FPGC4 interrupt sources and the CPU's interrupt input. It replaces the fixed set of directly wired sources (timers, UART RX, frameDrawn, external pins) with a generic block.
- It synchronises `CHANNELS` asynchronous sources.
- Each channel is edge- or level-sensitive, selectable per channel.
- Pending and overrun state is latched per channel, and pending interrupts can be masked.
- One request at a time is presented to the CPU over a fixed-priority req/ack handshake.

## Interface
Parameters:
- `CHANNELS`, 8, number of interrupt sources; legal range 1..32.
- `SYNC_STAGES`, 2, synchroniser depth per input; legal range 2..4.
- `EDGE_SEL`, {CHANNELS{1'b1}}, per-channel mode: 1 = rising-edge, 0 = level-high.
- `IDW`, derived: max(1, clog2(CHANNELS)); not user-set.

Ports:
- `clk`  in  1  system clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `irq_in`  in  CHANNELS  raw interrupt sources, asynchronous to `clk`.
- `mask_we`  in  1  load `mask_d` into the mask register.
- `mask_d`  in  CHANNELS  enable mask; 1 = channel enabled.
- `mask_q`  out  CHANNELS  current mask.
- `pending_q`  out  CHANNELS  current pending flags.
- `ovr_clr_we`  in  1  write-1-to-clear strobe for overrun flags.
- `ovr_clr_d`  in  CHANNELS  overrun bits to clear.
- `ovr_q`  out  CHANNELS  sticky overrun flags.
- `int_req`  out  1  interrupt request to the CPU.
- `int_id`  out  IDW  channel number of the current request.
- `int_ack`  in  1  CPU acknowledge, a single-cycle pulse.

## Operation
- **Synchroniser:** each `irq_in` bit passes through `SYNC_STAGES` flops, giving `s[i]`.
- **Edge detect:** a further flop holds `s_prev[i]`.
  - Edge channels: `set[i] = s[i] & ~s_prev[i]`.
  - Level channels: `set[i] = s[i]`.
- **Pending:** `pending[i]` is set by `set[i]`.
  - It is cleared by an accepted ack with `int_id == i`.
  - If set and clear occur in the same cycle, set wins.
  - Masking never blocks latching into `pending`.
- **Overrun:**
  - `ovr[i]` is set when `set[i]` occurs on an edge channel while `pending[i]` is already 1 and not being cleared that cycle.
  - Level channels never set `ovr`.
  - `ovr[i]` is cleared by `ovr_clr_we & ovr_clr_d[i]`; if set and clear coincide, set wins.
- **Mask:** loaded on `mask_we`; takes effect for arbitration from the next cycle.
- **Arbitration:**
  - Candidates are `pending & mask`.
  - The lowest index has highest priority.
- **FSM:** states IDLE, REQ, GAP.
  - **IDLE:** if any candidate exists, register `int_id` = winner and `int_req` = 1, then go to REQ.
  - **REQ:** `int_req` and `int_id` are frozen.
    - Later higher-priority arrivals, mask changes and pending changes do not alter them.
    - On `int_ack`: clear `pending[int_id]`, drop `int_req` next cycle, go to GAP.
  - **GAP:** one cycle with `int_req` = 0, then IDLE. This guarantees a low cycle between requests.
  - `int_ack` in IDLE or GAP is ignored and clears nothing.
- **Level channels:** the ack clears pending. If the source is still high, pending re-sets the following cycle and re-requests after GAP; the source must be quenched by software.
- **Reset:** asserting `nreset` at any time, including mid-REQ, aborts immediately and asynchronously.
  - All synchroniser flops and `s_prev` reset to 0.
  - A source that is high at reset release therefore registers as an edge.

## Timing
Reset values:
- `int_req` 0, `int_id` 0, FSM IDLE.
- `mask_q` 0 (all channels disabled), `pending_q` 0, `ovr_q` 0.

Latencies:
- `irq_in` rise sampled at clk edge 0: `pending_q[i]` = 1 after edge `SYNC_STAGES`, which is edge 2 at default.
- `int_req` rises one edge later, provided the channel is enabled and the FSM is in IDLE.
- `int_ack` high at edge n: at edge n, `pending` is cleared and the FSM enters GAP. `int_req` is low from edge n.
  - IDLE is reached at n+1.
  - The next `int_req` is asserted at n+2 at the earliest.
- `mask_we` at edge n enables arbitration using the new mask at edge n+1.

All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, `mask_d` = 0xFF, pulse `irq_in[3]` for 3 cycles -> `pending_q` = 0x08 after 2 edges, `int_req` = 1 with `int_id` = 3 one edge later; `int_ack` -> `pending_q` = 0x00, `int_req` = 0 for ≥1 cycle.
- `irq_in[5]` and `irq_in[1]` rise together -> `int_id` = 1 first; after ack and GAP, `int_id` = 5; `irq_in[0]` rising during REQ for id 5 does not change `int_id` until ack.
- `mask_q` = 0x00, pulse `irq_in[2]` -> `pending_q` = 0x04 and `int_req` stays 0; write `mask_d` = 0x04 -> `int_req` = 1, `int_id` = 2.
- Two `irq_in[4]` pulses 10 cycles apart, no ack -> `ovr_q` = 0x10; `ovr_clr_we` with `ovr_clr_d` = 0x10 -> `ovr_q` = 0x00; clear coinciding with a new overrun -> `ovr_q` stays 0x10.
- `EDGE_SEL[6]` = 0, hold `irq_in[6]` high -> after ack, `pending_q[6]` re-sets next cycle and a new request with `int_id` = 6 appears after GAP; edge flood on channel 0 with ack on the same cycle as a new edge -> `pending_q[0]` remains 1.
- Assert `nreset` while `int_req` = 1 -> all outputs return to 0 asynchronously; release with `irq_in[7]` held high and mask reprogrammed to 0x80 -> channel 7 is pended as an edge.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: synchronises CHANNELS asynchronous interrupt sources, latches
// pending/overrun state per channel and presents one fixed-priority request at a
// time to the CPU over a req/ack handshake.

module irq_controller #(
  parameter int unsigned            CHANNELS    = 8,
  parameter int unsigned            SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]    EDGE_SEL    = {CHANNELS{1'b1}},
  localparam int unsigned           IDW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic                mask_we,
  input  logic [CHANNELS-1:0] mask_d,
  output logic [CHANNELS-1:0] mask_q,
  output logic [CHANNELS-1:0] pending_q,
  input  logic                ovr_clr_we,
  input  logic [CHANNELS-1:0] ovr_clr_d,
  output logic [CHANNELS-1:0] ovr_q,
  output logic                int_req,
  output logic [IDW-1:0]      int_id,
  input  logic                int_ack
);

  // Elaboration-time guard on the legal parameter ranges.
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("irq_controller: CHANNELS must be in 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("irq_controller: SYNC_STAGES must be in 2..4");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StGap  = 2'd2
  } state_e;

  // Synchroniser chain, stage 0 samples the raw asynchronous inputs.
  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] r_s_prev;
  logic [CHANNELS-1:0] w_s;

  logic [CHANNELS-1:0] r_mask;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_ovr;

  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_cand;
  logic [CHANNELS-1:0] w_pending_nxt;
  logic [CHANNELS-1:0] w_ovr_set;
  logic [CHANNELS-1:0] w_ovr_clr;
  logic [CHANNELS-1:0] w_ovr_nxt;

  logic [IDW-1:0]      w_win;
  logic                w_ack_accept;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_int_req;
  logic                w_int_req_nxt;
  logic [IDW-1:0]      r_int_id;
  logic [IDW-1:0]      w_int_id_nxt;

  // Shift raw sources through the synchroniser; reset clears every stage so a
  // source high at reset release is seen as a fresh edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Hold the previous synchronised value for edge detection.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_s_prev <= '0;
    end else begin
      r_s_prev <= w_s;
    end
  end

  // Edge channels fire on a 0->1 transition, level channels whenever high.
  assign w_set = w_s & ~(r_s_prev & EDGE_SEL);

  // Decode the accepted acknowledge into a per-channel pending clear.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_clr[i] = w_ack_accept && (r_int_id == IDW'(i));
    end
  end

  // Pending and overrun next-state; a coincident set always beats a clear.
  always_comb begin
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
    w_ovr_set     = w_set & EDGE_SEL & r_pending & ~w_clr;
    w_ovr_clr     = ovr_clr_we ? ovr_clr_d : '0;
    w_ovr_nxt     = (r_ovr & ~w_ovr_clr) | w_ovr_set;
  end

  // Mask, pending and overrun registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_mask    <= '0;
      r_pending <= '0;
      r_ovr     <= '0;
    end else begin
      if (mask_we) begin
        r_mask <= mask_d;
      end
      r_pending <= w_pending_nxt;
      r_ovr     <= w_ovr_nxt;
    end
  end

  // Fixed-priority select: lowest enabled pending index wins.
  always_comb begin
    w_cand = r_pending & r_mask;
    w_win  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win = IDW'(i);
      end
    end
  end

  // FSM and registered request outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= StIdle;
      r_int_req <= 1'b0;
      r_int_id  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_int_req <= w_int_req_nxt;
      r_int_id  <= w_int_id_nxt;
    end
  end

  // Next-state: request is frozen while in StReq; StGap forces one low cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_int_req_nxt = r_int_req;
    w_int_id_nxt  = r_int_id;
    w_ack_accept  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|w_cand) begin
          w_int_req_nxt = 1'b1;
          w_int_id_nxt  = w_win;
          w_state_nxt   = StReq;
        end
      end
      StReq: begin
        if (int_ack) begin
          w_ack_accept  = 1'b1;
          w_int_req_nxt = 1'b0;
          w_state_nxt   = StGap;
        end
      end
      StGap: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_int_req_nxt = 1'b0;
        w_state_nxt   = StIdle;
      end
    endcase
  end

  assign mask_q    = r_mask;
  assign pending_q = r_pending;
  assign ovr_q     = r_ovr;
  assign int_req   = r_int_req;
  assign int_id    = r_int_id;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a scoreboard queue holds the channel
// ids expected on each new request, popped when int_req rises.

module tb_irq_controller;

  localparam int unsigned CH  = 8;
  localparam int unsigned IDW = 3;

  logic           clk;
  logic           nreset;
  logic [CH-1:0]  irq_in;
  logic           mask_we;
  logic [CH-1:0]  mask_d;
  logic [CH-1:0]  mask_q;
  logic [CH-1:0]  pending_q;
  logic           ovr_clr_we;
  logic [CH-1:0]  ovr_clr_d;
  logic [CH-1:0]  ovr_q;
  logic           int_req;
  logic [IDW-1:0] int_id;
  logic           int_ack;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IDW-1:0] exp_q [$];

  irq_controller #(
    .CHANNELS    (CH),
    .SYNC_STAGES (2),
    .EDGE_SEL    (8'hBF)
  ) u_dut (
    .clk        (clk),
    .nreset     (nreset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_d     (mask_d),
    .mask_q     (mask_q),
    .pending_q  (pending_q),
    .ovr_clr_we (ovr_clr_we),
    .ovr_clr_d  (ovr_clr_d),
    .ovr_q      (ovr_q),
    .int_req    (int_req),
    .int_id     (int_id),
    .int_ack    (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_mask(input logic [CH-1:0] m);
    mask_we = 1'b1;
    mask_d  = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic clr_ovr(input logic [CH-1:0] m);
    ovr_clr_we = 1'b1;
    ovr_clr_d  = m;
    tick();
    ovr_clr_we = 1'b0;
    ovr_clr_d  = '0;
  endtask

  // Wait (bounded) for a request and compare its id with the scoreboard head.
  task automatic wait_req(input string tag);
    int n = 0;
    while (int_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (int_req !== 1'b1) begin
      check({tag, "_timeout"}, 32'(int_req), 32'd1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      check(tag, 32'(int_id), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    nreset     = 1'b0;
    irq_in     = '0;
    mask_we    = 1'b0;
    mask_d     = '0;
    ovr_clr_we = 1'b0;
    ovr_clr_d  = '0;
    int_ack    = 1'b0;
    ticks(3);
    check("rst_req",  32'(int_req),   32'd0);
    check("rst_id",   32'(int_id),    32'd0);
    check("rst_mask", 32'(mask_q),    32'h00);
    check("rst_pend", 32'(pending_q), 32'h00);
    check("rst_ovr",  32'(ovr_q),     32'h00);
    nreset = 1'b1;
    tick();

    // Basic single-source request.
    write_mask(8'hFF);
    check("t1_mask", 32'(mask_q), 32'hFF);
    irq_in[3] = 1'b1;
    exp_q.push_back(3'd3);
    ticks(2);
    check("t1_pend_early", 32'(pending_q), 32'h00);
    tick();
    irq_in[3] = 1'b0;
    check("t1_pend", 32'(pending_q), 32'h08);
    check("t1_req_early", 32'(int_req), 32'd0);
    tick();
    check("t1_req_lat", 32'(int_req), 32'd1);
    wait_req("t1_id");
    ack();
    check("t1_pend_clr", 32'(pending_q), 32'h00);
    check("t1_req_low_n", 32'(int_req), 32'd0);
    tick();
    check("t1_req_low_n1", 32'(int_req), 32'd0);

    // Priority and frozen request.
    irq_in = 8'h22;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd5);
    wait_req("t2_first");
    ack();
    check("t2_gap", 32'(int_req), 32'd0);
    tick();
    check("t2_idle", 32'(int_req), 32'd0);
    tick();
    check("t2_rereq", 32'(int_req), 32'd1);
    wait_req("t2_second");
    irq_in = 8'h23;
    exp_q.push_back(3'd0);
    ticks(4);
    check("t2_frozen_id", 32'(int_id), 32'd5);
    check("t2_frozen_req", 32'(int_req), 32'd1);
    check("t2_pend", 32'(pending_q), 32'h21);
    ack();
    wait_req("t2_third");
    ack();
    irq_in = '0;
    ticks(3);
    check("t2_pend_clr", 32'(pending_q), 32'h00);

    // Masked pending then enabled.
    write_mask(8'h00);
    irq_in[2] = 1'b1;
    ticks(3);
    irq_in[2] = 1'b0;
    ticks(4);
    check("t3_pend", 32'(pending_q), 32'h04);
    check("t3_req_masked", 32'(int_req), 32'd0);
    write_mask(8'h04);
    exp_q.push_back(3'd2);
    check("t3_req_mask_n", 32'(int_req), 32'd0);
    tick();
    check("t3_req_mask_n1", 32'(int_req), 32'd1);
    wait_req("t3_id");
    ack();
    check("t3_pend_clr", 32'(pending_q), 32'h00);

    // Overrun: two edges with no ack, then clears.
    irq_in[4] = 1'b1;
    ticks(2);
    irq_in[4] = 1'b0;
    ticks(8);
    irq_in[4] = 1'b1;
    ticks(2);
    irq_in[4] = 1'b0;
    ticks(3);
    check("t4_pend", 32'(pending_q), 32'h10);
    check("t4_ovr", 32'(ovr_q), 32'h10);
    check("t4_req_masked", 32'(int_req), 32'd0);
    clr_ovr(8'h10);
    check("t4_ovr_clr", 32'(ovr_q), 32'h00);
    irq_in[4] = 1'b1;
    ticks(2);
    ovr_clr_we = 1'b1;
    ovr_clr_d  = 8'h10;
    tick();
    ovr_clr_we = 1'b0;
    ovr_clr_d  = '0;
    irq_in[4]  = 1'b0;
    check("t4_ovr_set_wins", 32'(ovr_q), 32'h10);
    write_mask(8'h10);
    exp_q.push_back(3'd4);
    wait_req("t4_id");
    ack();
    check("t4_pend_clr", 32'(pending_q), 32'h00);
    clr_ovr(8'h10);
    check("t4_ovr_final", 32'(ovr_q), 32'h00);

    // Level channel 6 held high re-requests after the gap.
    write_mask(8'hFF);
    irq_in[6] = 1'b1;
    exp_q.push_back(3'd6);
    wait_req("t5_lvl_first");
    ack();
    check("t5_lvl_gap", 32'(int_req), 32'd0);
    tick();
    check("t5_lvl_pend", 32'(pending_q[6]), 32'd1);
    check("t5_lvl_idle", 32'(int_req), 32'd0);
    exp_q.push_back(3'd6);
    tick();
    check("t5_lvl_rereq", 32'(int_req), 32'd1);
    wait_req("t5_lvl_second");
    irq_in[6] = 1'b0;
    ticks(3);
    ack();
    check("t5_lvl_pend_clr", 32'(pending_q), 32'h00);
    check("t5_lvl_no_ovr", 32'(ovr_q), 32'h00);

    // Edge flood on channel 0: new edge coincides with the ack.
    tick();
    irq_in[0] = 1'b1;
    exp_q.push_back(3'd0);
    wait_req("t5_flood_first");
    irq_in[0] = 1'b0;
    ticks(3);
    irq_in[0] = 1'b1;
    ticks(2);
    exp_q.push_back(3'd0);
    ack();
    check("t5_flood_pend", 32'(pending_q[0]), 32'd1);
    check("t5_flood_no_ovr", 32'(ovr_q), 32'h00);
    check("t5_flood_gap", 32'(int_req), 32'd0);
    wait_req("t5_flood_second");
    ack();
    irq_in[0] = 1'b0;
    check("t5_flood_pend_clr", 32'(pending_q), 32'h00);

    // Asynchronous reset mid-request, then edge from a source high at release.
    tick();
    irq_in = 8'h02;
    exp_q.push_back(3'd1);
    wait_req("t6_pre");
    #2;
    nreset = 1'b0;
    #1;
    check("t6_async_req",  32'(int_req),   32'd0);
    check("t6_async_id",   32'(int_id),    32'd0);
    check("t6_async_mask", 32'(mask_q),    32'h00);
    check("t6_async_pend", 32'(pending_q), 32'h00);
    check("t6_async_ovr",  32'(ovr_q),     32'h00);
    irq_in = 8'h80;
    ticks(2);
    nreset = 1'b1;
    write_mask(8'h80);
    tick();
    check("t6_pend_early", 32'(pending_q), 32'h00);
    tick();
    check("t6_pend_edge", 32'(pending_q), 32'h80);
    exp_q.push_back(3'd7);
    tick();
    check("t6_req", 32'(int_req), 32'd1);
    wait_req("t6_id");
    ack();
    check("t6_pend_clr", 32'(pending_q), 32'h00);
    ticks(4);
    check("t6_no_rereq", 32'(int_req), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
